// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the single-core datapath and its memory stand-in.
//   word_t            : 32-bit address / data word
//   responder_state_t : mem_hit_responder FSM states
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } responder_state_t;

    // Width of the latency down-counter; holds LAT-1 for LAT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/hit_ram.sv
// hit_ram
// DEPTH x 32 single-port word RAM behind mem_hit_responder.
// Ports:
//   CLK    in   clock, rising edge
//   we     in   write enable, commits wdata at the rising edge
//   windex in   word index for the write
//   wdata  in   write value
//   rindex in   word index for the asynchronous read
//   rdata  out  ram[rindex], combinational
// Contents are not reset.
module hit_ram
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] windex,
    input  word_t         wdata,
    input  logic [AW-1:0] rindex,
    output word_t         rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[windex] <= wdata;
        end
    end

    assign rdata = mem[rindex];

endmodule

// File: rtl/mem_hit_responder.sv
// mem_hit_responder
// Memory-side responder for the request-unit enable/hit protocol. Accepts
// one request at a time from IDLE (data over instruction), waits LAT cycles
// and pulses ihit/dhit for one cycle with the word read from hit_ram.
// Handshake: an enable (iREN, or dREN|dWEN) is a request held high by the
// requester until the matching hit; dropping it before the hit aborts the
// access with no hit and no write. The hit is the only completion signal.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, dREN, dWEN    request enables (dREN&dWEN together acts as a write)
//   iaddr, daddr        byte addresses, word index = addr[AW+1:2]
//   dstore              write data
//   ihit, dhit          one-cycle completion pulses
//   iload, dload        read data, zero outside the hit (dload zero on writes)
//   busy                high while not IDLE
//   icount, dcount      hit counters, only with MEM_HIT_COUNT_EN defined
module mem_hit_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t iaddr,
    input  word_t daddr,
    input  word_t dstore,
    output logic  ihit,
    output logic  dhit,
    output word_t iload,
    output word_t dload,
    output logic  busy
`ifdef MEM_HIT_COUNT_EN
    ,
    output word_t icount,
    output word_t dcount
`endif
);

    responder_state_t   state;
    logic [CNT_W-1:0]   cnt;
    logic [AW-1:0]      capIndex;
    word_t              capData;
    logic               capWr;
    word_t              ramRdata;
    logic               ramWe;
    logic               dReq;

    // Only the word-index bits of the addresses matter; the rest alias.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

    assign dReq = dREN | dWEN;

    // Hits are combinational on the last wait cycle; RST suppresses them so a
    // reset edge never coincides with a visible completion or a write.
    assign ihit  = (state == IWAIT) && (cnt == '0) && !RST;
    assign dhit  = (state == DWAIT) && (cnt == '0) && !RST;
    assign ramWe = dhit && capWr;
    assign busy  = (state != IDLE);

    assign iload = ihit ? ramRdata : '0;
    assign dload = (dhit && !capWr) ? ramRdata : '0;

    hit_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK    (CLK),
        .we     (ramWe),
        .windex (capIndex),
        .wdata  (capData),
        .rindex (capIndex),
        .rdata  (ramRdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            capIndex <= '0;
            capData  <= '0;
            capWr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dReq) begin
                        state    <= DWAIT;
                        capIndex <= daddr[AW+1:2];
                        capData  <= dstore;
                        capWr    <= dWEN;
                        cnt      <= CNT_W'(LAT - 1);
                    end else if (iREN) begin
                        state    <= IWAIT;
                        capIndex <= iaddr[AW+1:2];
                        capWr    <= 1'b0;
                        cnt      <= CNT_W'(LAT - 1);
                    end
                end
                IWAIT: begin
                    // Dropped enable aborts; the hit cycle always ends the wait.
                    if (!iREN || cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DWAIT: begin
                    if (!dReq || cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MEM_HIT_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (ihit) icount <= icount + 32'd1;
            if (dhit) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_hit_responder.sv
// tb_mem_hit_responder
// Self-checking bench for mem_hit_responder: directed scenarios followed by
// randomized transactions, checked against a transaction-level memory model.
// Covers the optional hit counters when MEM_HIT_COUNT_EN is defined.
module tb_mem_hit_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit, busy;
    logic [31:0] iload, dload;
`ifdef MEM_HIT_COUNT_EN
    logic [31:0] icount, dcount;
`endif

    mem_hit_responder #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .iREN   (iREN),
        .dREN   (dREN),
        .dWEN   (dWEN),
        .iaddr  (iaddr),
        .daddr  (daddr),
        .dstore (dstore),
        .ihit   (ihit),
        .dhit   (dhit),
        .iload  (iload),
        .dload  (dload),
        .busy   (busy)
`ifdef MEM_HIT_COUNT_EN
        ,
        .icount (icount),
        .dcount (dcount)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] memModel [DEPTH];
    logic [31:0] exp_q [$];
    int          expICount = 0;
    int          expDCount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word slot a byte address lands in, by plain arithmetic.
    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sampleOut();
        @(negedge CLK);
    endtask

    task automatic idleInputs();
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    task automatic checkCounts(input string tag);
`ifdef MEM_HIT_COUNT_EN
        check({tag, "_icount"}, icount, 32'(expICount));
        check({tag, "_dcount"}, dcount, 32'(expDCount));
`endif
    endtask

    // Compare the expected hit for this cycle against the DUT outputs.
    task automatic checkHits(input string tag, input bit expI, input bit expD);
        logic [31:0] e;
        check({tag, "_ihit"}, 32'(ihit), 32'(expI));
        check({tag, "_dhit"}, 32'(dhit), 32'(expD));
        if (expI || expD) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_iload"}, iload, expI ? e : 32'd0);
                check({tag, "_dload"}, dload, expD ? e : 32'd0);
            end
        end else begin
            check({tag, "_iload_idle"}, iload, 32'd0);
            check({tag, "_dload_idle"}, dload, 32'd0);
        end
    endtask

    // One transaction starting in an IDLE cycle. dropAt>0 drops the enable in
    // that cycle (before the hit cycle), which must abort the access.
    task automatic access(input string tag, input bit isData, input bit isWrite,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int dropAt);
        bit hitExp;
        bit busyExp;
        int w;
        w = wordOf(addr);
        if (isData) begin
            daddr  = addr;
            dstore = data;
            dREN   = !isWrite;
            dWEN   = isWrite;
        end else begin
            iaddr = addr;
            iREN  = 1'b1;
        end
        if (dropAt == 0) exp_q.push_back((isData && isWrite) ? 32'd0 : memModel[w]);
        for (int c = 0; c <= LAT; c++) begin
            if (c >= 1) begin
                // Address/data changes after capture must be ignored.
                iaddr  = $urandom;
                daddr  = $urandom;
                dstore = $urandom;
            end
            if (dropAt > 0 && c == dropAt) idleInputs();
            sampleOut();
            hitExp  = (dropAt == 0) && (c == LAT);
            busyExp = (c >= 1) && (dropAt == 0 || c <= dropAt);
            check({tag, "_busy"}, 32'(busy), 32'(busyExp));
            checkHits(tag, hitExp && !isData, hitExp && isData);
            if (c < LAT) nextCycle();
        end
        if (dropAt == 0) begin
            if (isData && isWrite) memModel[w] = data;
            if (isData) expDCount++;
            else expICount++;
        end
        nextCycle();
        idleInputs();
        sampleOut();
        check({tag, "_after_busy"}, 32'(busy), 32'd0);
        checkHits({tag, "_after"}, 1'b0, 1'b0);
        nextCycle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] oldWord;
        int          kind;
        int          drop;

        // Reset with every enable high: dREN&dWEN together is a write.
        RST    = 1'b1;
        iREN   = 1'b1;
        dREN   = 1'b1;
        dWEN   = 1'b1;
        iaddr  = 32'h0000_0000;
        daddr  = 32'h0000_0044;
        dstore = 32'h5A5A_1234;
        nextCycle();
        nextCycle();
        sampleOut();
        check("rst_busy", 32'(busy), 32'd0);
        checkHits("rst", 1'b0, 1'b0);
        checkCounts("rst");
        nextCycle();
        RST = 1'b0;
        exp_q.push_back(32'd0);
        for (int c = 0; c <= LAT; c++) begin
            sampleOut();
            checkHits("rst_first", 1'b0, c == LAT);
            if (c < LAT) nextCycle();
        end
        memModel[wordOf(32'h44)] = 32'h5A5A_1234;
        expDCount++;
        nextCycle();
        idleInputs();
        nextCycle();

        // Fill the whole RAM so every later read has a known value.
        for (int w = 0; w < DEPTH; w++) begin
            access("init", 1'b1, 1'b1, 32'(w * 4), $urandom, 0);
        end

        // Write then read back.
        access("wr10", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 0);
        access("ird10", 1'b0, 1'b0, 32'h10, 32'h0, 0);

        // Arbitration: data first, instruction after the data completes.
        iaddr = 32'h0000_0010;
        daddr = 32'h0000_0080;
        iREN  = 1'b1;
        dREN  = 1'b1;
        exp_q.push_back(memModel[wordOf(32'h80)]);
        exp_q.push_back(memModel[wordOf(32'h10)]);
        for (int c = 0; c <= 2 * LAT + 1; c++) begin
            if (c == LAT + 1) dREN = 1'b0;
            sampleOut();
            checkHits("arb", c == 2 * LAT + 1, c == LAT);
            if (c < 2 * LAT + 1) nextCycle();
        end
        expDCount++;
        expICount++;
        nextCycle();
        idleInputs();
        nextCycle();

        // Abort of a write leaves memory untouched.
        oldWord = memModel[wordOf(32'h20)];
        access("abort_wr", 1'b1, 1'b1, 32'h20, 32'h0000_1234, 1);
        access("abort_rd", 1'b1, 1'b0, 32'h20, 32'h0, 0);
        check("abort_model_kept", memModel[wordOf(32'h20)], oldWord);
        checkCounts("pre_midrst");

        // Reset in the middle of an instruction wait.
        iaddr = 32'h0000_0030;
        iREN  = 1'b1;
        sampleOut();
        check("midrst_k_busy", 32'(busy), 32'd0);
        nextCycle();
        RST = 1'b1;
        sampleOut();
        check("midrst_k1_busy", 32'(busy), 32'd1);
        checkHits("midrst_k1", 1'b0, 1'b0);
        nextCycle();
        RST  = 1'b0;
        iREN = 1'b0;
        sampleOut();
        check("midrst_k2_busy", 32'(busy), 32'd0);
        checkHits("midrst_k2", 1'b0, 1'b0);
        expICount = 0;
        expDCount = 0;
        checkCounts("midrst");
        nextCycle();

        // Address wrap: 0x400 aliases word 0.
        access("wrap_wr", 1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 0);
        access("wrap_rd", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 0);
        check("wrap_model", memModel[0], 32'hCAFE_F00D);
        checkCounts("wrap");

        // Randomized traffic, including occasional aborts.
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 2);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT - 1) : 0;
            access("rand", kind != 0, kind == 2, $urandom, $urandom, drop);
        end
        checkCounts("final");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
